// File: rtl/uart_tx_frame_if.sv
// Byte-producer to UART transmitter handshake.
//   data  : payload, sampled by the transmitter only on accept
//   valid : producer holds a payload on data
//   ready : transmitter can take a payload (idle)
// master = producer side, slave = transmitter side.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS payload bits LSB first, optional
// odd/even parity, 1 or 2 stop bits. The baud counter restarts on every
// accepted byte so each frame is bit-aligned to its accept edge.
// Ports:
//   sysclk : system clock, posedge
//   rst_n  : asynchronous active-low reset (aborts a frame, line to idle)
//   in_if  : slave side of the data/valid/ready handshake
//   cereal : serial line, idle high (registered)
//   busy   : high whenever not IDLE (registered)
//   done   : one-cycle pulse in the final cycle of the last stop bit
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          sysclk,
  input  logic          rst_n,
  uart_tx_frame_if.slave in_if,
  output logic          cereal,
  output logic          busy,
  output logic          done
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 1 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $error("uart_tx_frame: parameter out of range");
  end

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;   // data bit index, reused as stop bit index
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 cereal_q, cereal_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tc;

  // State register; line/busy/done are registered from next-state values,
  // so the start bit appears in the cycle right after the accept edge.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      cereal_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      cereal_q <= cereal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tc = (cnt_q == CNT_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    // Counter sits at 0 in IDLE, so an accept always starts a fresh bit.
    cnt_d   = (state_q == S_IDLE || tc) ? '0 : cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (in_if.valid) begin
          state_d = S_START;
          idx_d   = '0;
          shreg_d = in_if.data;
          par_d   = (PARITY == 2) ? ^in_if.data : ~^in_if.data;
        end
      end
      S_START: begin
        if (tc) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (tc) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tc) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (tc) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic, evaluated on next-state values ahead of the registers.
  always_comb begin
    cereal_d = 1'b1;
    case (state_d)
      S_START:  cereal_d = 1'b0;
      S_DATA:   cereal_d = shreg_d[0];
      S_PARITY: cereal_d = par_d;
      default:  cereal_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    // The coming cycle is the terminal cycle of the last stop bit.
    done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST) && (idx_d == STOP_LAST);
  end

  assign in_if.ready = (state_q == S_IDLE);
  assign cereal      = cereal_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
